// File: rtl/inst_encoder_writer_pkg.sv
// Shared constants for the instruction encoder/loader: MIPS opcodes,
// descriptor class codes and the writer FSM state encoding.
package inst_encoder_writer_pkg;

  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;
  localparam logic [5:0] EXE_BEQ     = 6'b000100;
  localparam logic [5:0] EXE_ADDI    = 6'b001000;
  localparam logic [5:0] EXE_J       = 6'b000010;

  localparam logic [2:0] CLS_R    = 3'd0;
  localparam logic [2:0] CLS_LW   = 3'd1;
  localparam logic [2:0] CLS_SW   = 3'd2;
  localparam logic [2:0] CLS_BEQ  = 3'd3;
  localparam logic [2:0] CLS_ADDI = 3'd4;
  localparam logic [2:0] CLS_J    = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } state_t;

endpackage

// File: rtl/inst_encoder_writer_if.sv
// Descriptor handshake between a program source (master) and the loader (slave).
interface inst_encoder_writer_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_class;
  logic [4:0]  in_rs;
  logic [4:0]  in_rt;
  logic [4:0]  in_rd;
  logic [4:0]  in_shamt;
  logic [5:0]  in_funct;
  logic [15:0] in_imm;
  logic [25:0] in_target;

  modport master (
    output in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_class, in_rs, in_rt, in_rd, in_shamt,
           in_funct, in_imm, in_target,
    output in_ready
  );
endinterface

// File: rtl/inst_encoder_writer_encode.sv
// Combinational descriptor -> 32-bit MIPS word encoder; classes 6..7 flag illegal.
module inst_encoder_writer_encode
  import inst_encoder_writer_pkg::*;
(
  input  logic [2:0]  cls_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [5:0]  funct_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (cls_i)
      CLS_R:    word_o = {EXE_SPECIAL, rs_i, rt_i, rd_i, shamt_i, funct_i};
      CLS_LW:   word_o = {EXE_LW,   rs_i, rt_i, imm_i};
      CLS_SW:   word_o = {EXE_SW,   rs_i, rt_i, imm_i};
      CLS_BEQ:  word_o = {EXE_BEQ,  rs_i, rt_i, imm_i};
      CLS_ADDI: word_o = {EXE_ADDI, rs_i, rt_i, imm_i};
      CLS_J:    word_o = {EXE_J, target_i};
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/inst_encoder_writer.sv
// Program loader: accepts instruction descriptors, encodes them and writes
// them to consecutive imem words until DEPTH words are written.
module inst_encoder_writer
  import inst_encoder_writer_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  inst_encoder_writer_if.slave  bus,
  output logic                  imem_we,
  output logic [ADDR_W-1:0]     imem_addr,
  output logic [31:0]           imem_wdata,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err
);

  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic                err_q, err_d;
  logic [31:0]         word_q, word_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         enc_word;
  logic                enc_illegal;
  logic                accept;

  inst_encoder_writer_encode u_encode (
    .cls_i     (bus.in_class),
    .rs_i      (bus.in_rs),
    .rt_i      (bus.in_rt),
    .rd_i      (bus.in_rd),
    .shamt_i   (bus.in_shamt),
    .funct_i   (bus.in_funct),
    .imm_i     (bus.in_imm),
    .target_i  (bus.in_target),
    .word_o    (enc_word),
    .illegal_o (enc_illegal)
  );

  // Count doubles as the write pointer; it never wraps since full stops accepts.
  assign full         = (count_q == DEPTH_W);
  assign bus.in_ready = (state_q == S_IDLE) && !full && !clear && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  assign imem_we    = (state_q == S_WRITE);
  assign imem_addr  = addr_q;
  assign imem_wdata = word_q;
  assign count      = count_q;
  assign err        = err_q;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    err_d   = err_q;
    word_d  = word_q;
    addr_d  = addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (enc_illegal) begin
            err_d = 1'b1;
          end else begin
            word_d  = enc_word;
            addr_d  = count_q[ADDR_W-1:0];
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = (count_d == DEPTH_W) ? S_FULL : S_IDLE;
      end
      S_FULL:  state_d = S_FULL;
      default: state_d = S_IDLE;
    endcase
    // A write in flight still completes this cycle; clear wins afterwards.
    if (clear) begin
      count_d = '0;
      err_d   = 1'b0;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      err_q   <= 1'b0;
      word_q  <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      err_q   <= err_d;
      word_q  <= word_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: doc/inst_encoder_writer.md
Name: inst_encoder_writer

Overview:
- Encoding-side counterpart of the main control decoder: accepts instruction descriptors (class plus register/immediate fields) over a valid/ready handshake.
- Assembles each descriptor into a 32-bit MIPS word and writes it into instruction memory at consecutive word addresses.
- Used as the on-chip program loader and self-test stimulus source ahead of fetch/decode.
- Covers exactly the opcode set the decoder handles: R-type, LW, SW, BEQ, ADDI, J.

Parameters:
- ADDR_W, 8, width of the imem word address.
- DEPTH, 256, number of writable words (DEPTH <= 2**ADDR_W).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous: pointer to 0, clear err and full.
- in_valid  in  1  descriptor valid.
- in_ready  out  1  block can accept a descriptor this cycle.
- in_class  in  3  0=R, 1=LW, 2=SW, 3=BEQ, 4=ADDI, 5=J, 6..7 illegal.
- in_rs, in_rt, in_rd, in_shamt  in  5 each  register and shift fields.
- in_funct  in  6  R-type function code.
- in_imm  in  16  immediate or branch offset.
- in_target  in  26  jump target.
- imem_we  out  1  imem write strobe.
- imem_addr  out  ADDR_W  word address.
- imem_wdata  out  32  encoded instruction.
- count  out  ADDR_W+1  words written since reset or clear.
- full  out  1  count == DEPTH.
- err  out  1  sticky flag: an illegal class was accepted.

Behaviour:
- Reset (async, rst=1): state S_IDLE; in_ready=0 while rst is high; imem_we=0; imem_addr=0; imem_wdata=0; count=0; full=0; err=0.
- FSM states: S_IDLE, S_WRITE, S_FULL.
- S_IDLE:
  - in_ready = !full && !clear.
  - Accept = in_valid && in_ready.
  - On accept of a legal class: register the encoded word and go to S_WRITE.
  - On accept of an illegal class: set err, do not write, stay in S_IDLE.
- S_WRITE:
  - imem_we=1 for exactly one cycle; imem_addr = pointer; imem_wdata = registered word; in_ready=0.
  - At the end of the cycle: pointer and count increment.
  - Next state: S_FULL if the new count == DEPTH, else S_IDLE.
- S_FULL: in_ready=0, full=1. The only exits are clear or rst.
- Latency and throughput: a descriptor accepted in cycle N is written in cycle N+1. Maximum rate is one descriptor per 2 cycles.
- Encoding:
  - R: {6'b000000, rs, rt, rd, shamt, funct}.
  - LW: {6'b100011, rs, rt, imm}.
  - SW: {6'b101011, rs, rt, imm}.
  - BEQ: {6'b000100, rs, rt, imm}.
  - ADDI: {6'b001000, rs, rt, imm}.
  - J: {6'b000010, target}.
  - Fields not used by a class are ignored. imm is passed through unmodified, with no sign handling.
- Address: imem_addr = pointer[ADDR_W-1:0]. The pointer never wraps, because full blocks further accepts.
- clear:
  - Takes priority over an accept in the same cycle (in_ready=0, so nothing is accepted).
  - In S_WRITE, the pending write completes in that cycle. Then pointer, count, full and err all go to 0 and the state is S_IDLE.
- Simultaneous illegal accept and full: impossible, because in_ready=0 when full.
- rst mid-write: imem_we drops immediately (async). The pending word is discarded.
- imem_wdata and imem_addr hold their last values when imem_we=0.

Decomposition:
- Shared package / defines header:
  - Opcode constants, reusing the decoder's EXE_* opcode macros (SPECIAL, LW, SW, BEQ, ADDI, J).
  - New class codes CLS_R..CLS_J.
  - FSM state encodings.
- One sub-module is natural: inst_encode, the combinational class+fields -> 32-bit word encoder with an illegal flag. The top module keeps the FSM, pointer and flags.

Test Plan:
- ADDI rs=0 rt=8 imm=5 after reset -> cycle+1: imem_we=1, addr=0, wdata=0x20080005; then count=1.
- Back-to-back descriptors with in_valid held high:
  - LW rs=29 rt=8 imm=4 -> 0x8FA80004 at addr 0.
  - SW rs=29 rt=9 imm=8 -> 0xAFA90008 at addr 1.
  - Check in_ready toggles 1,0,1,0.
- Remaining classes, written to consecutive addresses:
  - R rs=8 rt=9 rd=10 shamt=0 funct=0x20 -> 0x01095020.
  - BEQ rs=8 rt=9 imm=0xFFFF -> 0x1109FFFF.
  - J target=0x10 -> 0x08000010.
- Illegal class 7 -> no imem_we, err=1 and sticky, count unchanged. The next legal descriptor is still written.
- DEPTH=4: write 4 words -> full=1, in_ready=0, and a 5th valid is never accepted. Assert clear -> count=0, full=0. The next write lands at addr 0.
- Assert rst during S_WRITE -> imem_we=0 immediately, all outputs at reset values. clear asserted together with in_valid -> no accept.
